// File: rtl/c_mutex_split5_stream_inst.sv
// One-to-five stream demultiplexer: a single upstream requester is routed to one of
// five mutually exclusive destinations, with at most one transfer in flight.
module c_mutex_split5_stream_inst #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [2:0]        i_sel,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_free,
    output logic              o_drive0,
    output logic              o_drive1,
    output logic              o_drive2,
    output logic              o_drive3,
    output logic              o_drive4,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_free0,
    input  logic              i_free1,
    input  logic              i_free2,
    input  logic              i_free3,
    input  logic              i_free4,
    output logic              o_busy,
    output logic [1:0]        o_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [4:0]          drive_q, drive_d;
    logic                free_q, free_d;
    logic [1:0]          err_q, err_d;

    logic [7:0]          free_ext;
    logic                tgt_free;
    logic                sel_ok;
    logic [4:0]          sel_onehot;

    // Padding to 8 entries lets the 3-bit latched select index safely.
    assign free_ext = {3'b000, i_free4, i_free3, i_free2, i_free1, i_free0};
    assign tgt_free = free_ext[sel_q];
    assign sel_ok   = (i_sel <= 3'd4);

    always_comb begin
        sel_onehot = 5'b00000;
        case (i_sel)
            3'd0:    sel_onehot = 5'b00001;
            3'd1:    sel_onehot = 5'b00010;
            3'd2:    sel_onehot = 5'b00100;
            3'd3:    sel_onehot = 5'b01000;
            3'd4:    sel_onehot = 5'b10000;
            default: sel_onehot = 5'b00000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        drive_d = 5'b00000;
        free_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (i_drive) begin
                    if (sel_ok) begin
                        sel_d   = i_sel;
                        data_d  = i_data;
                        drive_d = sel_onehot;
                        state_d = WAIT;
                    end else begin
                        // Bad select is refused immediately so upstream is not stalled.
                        err_d[0] = 1'b1;
                        free_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (i_drive) begin
                    err_d[1] = 1'b1;
                end
                if (tgt_free) begin
                    free_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            data_q  <= '0;
            drive_q <= 5'b00000;
            free_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            drive_q <= drive_d;
            free_q  <= free_d;
            err_q   <= err_d;
        end
    end

    assign o_drive0 = drive_q[0];
    assign o_drive1 = drive_q[1];
    assign o_drive2 = drive_q[2];
    assign o_drive3 = drive_q[3];
    assign o_drive4 = drive_q[4];
    assign o_free   = free_q;
    assign o_data   = data_q;
    assign o_busy   = (state_q == WAIT);
    assign o_err    = err_q;

endmodule

// File: tb/tb_c_mutex_split5_stream_inst.sv
// Bench for the 5-way stream demultiplexer: directed vector table, hand-written
// reset/collision sequences, then randomized traffic against a transaction model.
module tb_c_mutex_split5_stream_inst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_in = 1'b0;
    logic [2:0]  sel_in = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [4:0]  fr = 5'd0;

    logic        o_free, o_drive0, o_drive1, o_drive2, o_drive3, o_drive4, o_busy;
    logic [31:0] o_data;
    logic [1:0]  o_err;
    logic [4:0]  drv_out;

    int checks = 0;
    int errors = 0;

    assign drv_out = {o_drive4, o_drive3, o_drive2, o_drive1, o_drive0};

    c_mutex_split5_stream_inst #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_drive(drv_in), .i_sel(sel_in), .i_data(data_in),
        .o_free(o_free),
        .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
        .o_drive3(o_drive3), .o_drive4(o_drive4),
        .o_data(o_data),
        .i_free0(fr[0]), .i_free1(fr[1]), .i_free2(fr[2]), .i_free3(fr[3]), .i_free4(fr[4]),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dr;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [4:0]  fr;
        logic [4:0]  e_drv;
        logic        e_free;
        logic        e_busy;
        logic [1:0]  e_err;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_drv, input logic e_free,
                           input logic e_busy, input logic [1:0] e_err, input logic [31:0] e_data);
        chk({tag, ".drive"}, {27'd0, drv_out}, {27'd0, e_drv});
        chk({tag, ".free"},  {31'd0, o_free},  {31'd0, e_free});
        chk({tag, ".busy"},  {31'd0, o_busy},  {31'd0, e_busy});
        chk({tag, ".err"},   {30'd0, o_err},   {30'd0, e_err});
        chk({tag, ".data"},  o_data,           e_data);
    endtask

    // Apply one cycle of inputs, then sample outputs just after the edge.
    task automatic step(input logic dr, input logic [2:0] sel, input logic [31:0] data,
                        input logic [4:0] f);
        drv_in  = dr;
        sel_in  = sel;
        data_in = data;
        fr      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv_in = 1'b0; sel_in = 3'd0; data_in = 32'd0; fr = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 5'd0, 1'b0, 1'b0, 2'b00, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[$];

    // Transaction-level reference for random traffic.
    bit          m_pend;
    int          m_tgt;
    logic [31:0] m_pay;
    logic [1:0]  m_err;

    initial begin
        // Directed table: each row is one cycle, expectations are the outputs after its edge.
        vt.push_back('{1, 3'd3, 32'hA5A5_0003, 5'b00000, 5'b01000, 0, 1, 2'b00, 32'hA5A5_0003});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00000, 5'b00000, 0, 1, 2'b00, 32'hA5A5_0003});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00000, 5'b00000, 0, 1, 2'b00, 32'hA5A5_0003});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00000, 5'b00000, 0, 1, 2'b00, 32'hA5A5_0003});
        vt.push_back('{0, 3'd0, 32'h0,         5'b01000, 5'b00000, 1, 0, 2'b00, 32'hA5A5_0003});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00000, 5'b00000, 0, 0, 2'b00, 32'hA5A5_0003});
        vt.push_back('{1, 3'd1, 32'h1111_1111, 5'b00000, 5'b00010, 0, 1, 2'b00, 32'h1111_1111});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00001, 5'b00000, 0, 1, 2'b00, 32'h1111_1111});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00100, 5'b00000, 0, 1, 2'b00, 32'h1111_1111});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00010, 5'b00000, 1, 0, 2'b00, 32'h1111_1111});
        vt.push_back('{1, 3'd6, 32'hDEAD_BEEF, 5'b00000, 5'b00000, 1, 0, 2'b01, 32'h1111_1111});
        vt.push_back('{1, 3'd0, 32'h0000_0C0C, 5'b00000, 5'b00001, 0, 1, 2'b01, 32'h0000_0C0C});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00001, 5'b00000, 1, 0, 2'b01, 32'h0000_0C0C});
        vt.push_back('{1, 3'd2, 32'h2222_2222, 5'b00000, 5'b00100, 0, 1, 2'b01, 32'h2222_2222});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00100, 5'b00000, 1, 0, 2'b01, 32'h2222_2222});
        vt.push_back('{1, 3'd0, 32'h3333_3333, 5'b00000, 5'b00001, 0, 1, 2'b01, 32'h3333_3333});
        vt.push_back('{0, 3'd0, 32'h0,         5'b00001, 5'b00000, 1, 0, 2'b01, 32'h3333_3333});
        vt.push_back('{0, 3'd0, 32'h0,         5'b11111, 5'b00000, 0, 0, 2'b01, 32'h3333_3333});
        vt.push_back('{1, 3'd5, 32'h5555_5555, 5'b00000, 5'b00000, 1, 0, 2'b01, 32'h3333_3333});
        vt.push_back('{1, 3'd7, 32'h7777_7777, 5'b00000, 5'b00000, 1, 0, 2'b01, 32'h3333_3333});

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].dr, vt[i].sel, vt[i].data, vt[i].fr);
            chk_all($sformatf("vec%0d", i), vt[i].e_drv, vt[i].e_free, vt[i].e_busy,
                    vt[i].e_err, vt[i].e_data);
        end

        // Drive collides with the accepted release: one o_free, no new drive, busy error.
        do_reset();
        step(1, 3'd4, 32'h4444_4444, 5'b00000);
        chk_all("coll.drv", 5'b10000, 0, 1, 2'b00, 32'h4444_4444);
        step(1, 3'd0, 32'h9999_9999, 5'b10000);
        chk_all("coll.free", 5'b00000, 1, 0, 2'b10, 32'h4444_4444);
        step(0, 3'd0, 32'h0, 5'b00000);
        chk_all("coll.idle", 5'b00000, 0, 0, 2'b10, 32'h4444_4444);

        // Reset mid-transfer abandons it; later release is ignored, next drive is taken.
        do_reset();
        step(1, 3'd2, 32'h2020_2020, 5'b00000);
        chk_all("rstmid.drv", 5'b00100, 0, 1, 2'b00, 32'h2020_2020);
        step(1, 3'd1, 32'h0, 5'b00000);
        chk_all("rstmid.wait", 5'b00000, 0, 1, 2'b10, 32'h2020_2020);
        drv_in = 1'b0; fr = 5'd0;
        #2 rst = 1'b1;
        #1 chk_all("rstmid.async", 5'b00000, 0, 0, 2'b00, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 3'd0, 32'h0, 5'b00100);
        chk_all("rstmid.free", 5'b00000, 0, 0, 2'b00, 32'h0);
        step(0, 3'd0, 32'h0, 5'b00000);
        chk_all("rstmid.quiet", 5'b00000, 0, 0, 2'b00, 32'h0);
        do_reset();
        step(1, 3'd3, 32'hCAFE_0003, 5'b00000);
        chk_all("rstfirst.drv", 5'b01000, 0, 1, 2'b00, 32'hCAFE_0003);

        // Randomized traffic.
        do_reset();
        m_pend = 0; m_tgt = 0; m_pay = 32'd0; m_err = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            logic        r_dr;
            logic [2:0]  r_sel;
            logic [31:0] r_data;
            logic [4:0]  r_fr;
            logic [4:0]  e_drv;
            logic        e_free;
            r_dr   = ($urandom_range(0, 9) < 4);
            r_sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            r_data = $urandom;
            r_fr   = 5'd0;
            for (int k = 0; k < 5; k++) r_fr[k] = ($urandom_range(0, 9) < 2);
            e_drv  = 5'd0;
            e_free = 1'b0;
            if (!m_pend) begin
                if (r_dr) begin
                    if (r_sel < 5) begin
                        m_pend = 1; m_tgt = int'(r_sel); m_pay = r_data;
                        e_drv[m_tgt] = 1'b1;
                    end else begin
                        m_err[0] = 1'b1;
                        e_free = 1'b1;
                    end
                end
            end else begin
                if (r_dr) m_err[1] = 1'b1;
                if (r_fr[m_tgt]) begin
                    m_pend = 0;
                    e_free = 1'b1;
                end
            end
            step(r_dr, r_sel, r_data, r_fr);
            chk_all($sformatf("rnd%0d", n), e_drv, e_free, m_pend, m_err, m_pay);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_mutex_split5_stream_inst.md
C_MUTEX_SPLIT5_STREAM_INST -- requirements
Module: c_mutex_split5_stream_inst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning stream-instruction payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_drive  input  1  upstream request, one-cycle pulse.
REQ-005 SHALL have port i_sel  input  3  destination index 0..4, sampled with i_drive.
REQ-006 SHALL have port i_data  input  DATA_W  payload, sampled with i_drive.
REQ-007 SHALL have port o_free  output  1  upstream release, one-cycle pulse.
REQ-008 SHALL have ports o_drive0..o_drive4  output  1 each  per-destination request, one-cycle pulse.
REQ-009 SHALL have port o_data  output  DATA_W  payload presented to the selected destination.
REQ-010 SHALL have ports i_free0..i_free4  input  1 each  per-destination release, one-cycle pulse.
REQ-011 SHALL have port o_busy  output  1  high while a transfer is outstanding.
REQ-012 SHALL have port o_err  output  2  sticky errors: bit0 invalid select, bit1 drive while busy.

Function
REQ-013 SHALL implement the demultiplexing counterpart of the 5-way mutex merge: one upstream requester, five mutually exclusive destinations, at most one transfer outstanding.
REQ-014 SHALL use two states, IDLE and WAIT; o_busy = (state == WAIT).
REQ-015 In IDLE, i_drive=1 with i_sel<=4 SHALL latch i_sel and i_data, enter WAIT and assert o_drive[i_sel] for exactly the next cycle (latency 1).
REQ-016 o_data SHALL equal the latched payload from the o_drive cycle until the next accepted transfer; it SHALL NOT follow i_data otherwise.
REQ-017 In WAIT, i_free[K] with K = latched select SHALL, in the next cycle, pulse o_free for one cycle and return to IDLE.
REQ-018 i_free[K] SHALL be accepted in any WAIT cycle, including the cycle o_drive[K] is high.
REQ-019 i_free on any non-selected destination, or any i_free in IDLE, SHALL be ignored with no state or error change.
REQ-020 The cycle o_free pulses is an IDLE cycle; i_drive in that cycle SHALL be accepted normally (back-to-back throughput: one transfer per 2 cycles minimum).
REQ-021 In IDLE, i_drive=1 with i_sel in 5..7 SHALL issue no o_drive, set o_err[0], pulse o_free the next cycle, and remain IDLE.
REQ-022 In WAIT, i_drive=1 SHALL be dropped (no latch, no extra o_drive/o_free) and set o_err[1], including when it coincides with the accepted i_free[K].
REQ-023 At most one of o_drive0..4 SHALL be high in any cycle; o_drive and o_free SHALL never both be high in the same cycle.
REQ-024 o_err bits SHALL be sticky and cleared only by rst.
REQ-025 All outputs SHALL be driven from registers (no combinational input-to-output path).

Reset
REQ-026 rst=1 SHALL immediately force state IDLE and o_drive0..4=0, o_free=0, o_busy=0, o_data=0, o_err=0, latched select=0.
REQ-027 rst asserted mid-transfer SHALL abandon the transfer; no o_free SHALL be emitted for it after rst deasserts.
REQ-028 In the first clk edge after rst deasserts, i_drive SHALL be accepted.

Verification
REQ-029 i_drive, i_sel=3, i_data=0xA5A5_0003 at T -> o_drive3=1 only at T+1, o_data=0xA5A5_0003, o_busy=1; i_free3 at T+4 -> o_free=1 at T+5 only, o_busy=0 at T+5.
REQ-030 Transfer to sel=1 outstanding; pulse i_free0, i_free2 -> no o_free, o_busy stays 1; then i_free1 -> o_free next cycle.
REQ-031 i_sel=6 with i_drive in IDLE -> no o_drive, o_free at next cycle, o_err=2'b01, next valid drive proceeds normally.
REQ-032 Transfer to sel=4 pending; i_drive (sel=0) in same cycle as i_free4 -> single o_free, no o_drive0, o_err=2'b10, state IDLE.
REQ-033 i_free2 driven in the o_drive2 cycle, then i_drive (sel=0) in the o_free cycle -> o_free, then o_drive0 next cycle; throughput 2 cycles/transfer.
REQ-034 rst pulsed while WAIT on sel=2, i_free2 after release -> no o_free, all outputs 0, o_err=0.
